// File: rtl/oam_dma_if.sv
// Bus bundle between the CPU, the OAM DMA engine and the block SRAM.
// The engine takes the slave view; the surrounding system takes the master view.
interface oam_dma_if;
   logic [15:0] cpu_address;
   logic [7:0]  cpu_wdata;
   logic [7:0]  cpu_rdata;
   logic        cpu_RE;
   logic        cpu_WE;
   logic [15:0] mem_address;
   logic [7:0]  mem_wdata;
   logic [7:0]  mem_rdata;
   logic        mem_RE;
   logic        mem_WE;
   logic        dma_active;

   modport slave (
      input  cpu_address, cpu_wdata, cpu_RE, cpu_WE, mem_rdata,
      output cpu_rdata, mem_address, mem_wdata, mem_RE, mem_WE, dma_active
   );

   modport master (
      output cpu_address, cpu_wdata, cpu_RE, cpu_WE, mem_rdata,
      input  cpu_rdata, mem_address, mem_wdata, mem_RE, mem_WE, dma_active
   );
endinterface

// File: rtl/oam_dma.sv
// OAM DMA engine: owns the SRAM port, copies one 160-byte source page into OAM
// using a read/write cycle pair per byte, and locks the CPU out while copying.
module oam_dma #(
   parameter logic [15:0] DMA_REG_ADDR = 16'hFF46,
   parameter logic [15:0] OAM_BASE     = 16'hFE00,
   parameter int          DMA_LENGTH   = 160,
   parameter bit          ECHO_MASK_EN = 1'b1
) (
   input logic      clk,
   input logic      rst,
   oam_dma_if.slave bus
);
   typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

   localparam logic [7:0] LAST_IDX = 8'(DMA_LENGTH - 1);

   state_t     state, state_nxt;
   logic [7:0] src_hi, src_hi_nxt;
   logic [7:0] idx, idx_nxt;
   logic [7:0] byte_latch, byte_latch_nxt;
   logic       dma_active, dma_active_nxt;
   logic       reg_hit;
   logic       trigger;
   logic [7:0] eff_hi;

   assign reg_hit        = (bus.cpu_address == DMA_REG_ADDR);
   assign trigger        = bus.cpu_WE && reg_hit;
   // Echo RAM pages E0-FF alias the work RAM pages C0-DF.
   assign eff_hi         = (ECHO_MASK_EN && (src_hi >= 8'hE0)) ? (src_hi - 8'h20) : src_hi;
   assign bus.dma_active = dma_active;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         src_hi     <= 8'h00;
         idx        <= 8'h00;
         byte_latch <= 8'h00;
         dma_active <= 1'b0;
      end else begin
         state      <= state_nxt;
         src_hi     <= src_hi_nxt;
         idx        <= idx_nxt;
         byte_latch <= byte_latch_nxt;
         dma_active <= dma_active_nxt;
      end
   end

   always_comb begin
      state_nxt       = state;
      src_hi_nxt      = src_hi;
      idx_nxt         = idx;
      byte_latch_nxt  = byte_latch;
      dma_active_nxt  = dma_active;
      bus.mem_address = bus.cpu_address;
      bus.mem_wdata   = bus.cpu_wdata;
      bus.mem_RE      = bus.cpu_RE && !reg_hit;
      bus.mem_WE      = bus.cpu_WE && !reg_hit;
      bus.cpu_rdata   = reg_hit ? src_hi : bus.mem_rdata;

      unique case (state)
         IDLE: begin
         end
         READ: begin
            bus.mem_address = {eff_hi, idx};
            bus.mem_wdata   = byte_latch;
            bus.mem_RE      = 1'b1;
            bus.mem_WE      = 1'b0;
            bus.cpu_rdata   = reg_hit ? src_hi : 8'hFF;
            byte_latch_nxt  = bus.mem_rdata;
            state_nxt       = WRITE;
         end
         WRITE: begin
            bus.mem_address = OAM_BASE + {8'h00, idx};
            bus.mem_wdata   = byte_latch;
            bus.mem_RE      = 1'b0;
            bus.mem_WE      = 1'b1;
            bus.cpu_rdata   = reg_hit ? src_hi : 8'hFF;
            if (idx == LAST_IDX) begin
               state_nxt      = IDLE;
               dma_active_nxt = 1'b0;
            end else begin
               idx_nxt   = idx + 8'd1;
               state_nxt = READ;
            end
         end
         default: state_nxt = IDLE;
      endcase

      // A register write (re)starts the copy; an in-flight WRITE still drives the bus this cycle.
      if (trigger) begin
         src_hi_nxt     = bus.cpu_wdata;
         idx_nxt        = 8'h00;
         state_nxt      = READ;
         dma_active_nxt = 1'b1;
      end
   end
endmodule
